pow4_sched: RTL

Controller and two-port round-robin arbiter that shares a single pipelined squaring multiplier between two requesters. Each job computes the fourth power of an unsigned operand with two sequenced passes through the multiplier: x², then (x²)². The block sits in front of the multiplier datapath and replaces per-requester multiplier trees with one shared, sequenced unit.

---
 rtl/pow4_pkg.sv | 33 +++
 rtl/pow4_sched_mul_pipe.sv | 54 +++++
 rtl/pow4_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/pow4_pkg.sv
// Shared types and constants for the pow4_sched block: FSM states, product widths
// for the default operand width, requester count and the round-robin pick.
package pow4_pkg;

  localparam int W_DEF = 8;
  localparam int P2_W  = 2 * W_DEF;
  localparam int P4_W  = 4 * W_DEF;
  localparam int NREQ  = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ISS1 = 3'd1,
    WT1  = 3'd2,
    ISS2 = 3'd3,
    WT2  = 3'd4,
    OUT  = 3'd5
  } state_e;

  // One-hot grant for two requesters; on a tie the one that did not win last time goes.
  function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] req,
                                                input logic            last);
    logic [NREQ-1:0] g;
    g = '0;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/pow4_sched_mul_pipe.sv
// Two-stage unsigned multiplier: operands registered on issue, product one cycle later.
// Each stage only loads when its valid bit is set, so the product holds while idle.
module mul_pipe
  import pow4_pkg::*;
#(
  parameter int AW = P2_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [AW-1:0]   a,
  input  logic [AW-1:0]   b,
  output logic [2*AW-1:0] p,
  output logic            p_valid
);

  logic [AW-1:0]   a_q, a_d;
  logic [AW-1:0]   b_q, b_d;
  logic            v1_q, v1_d;
  logic [2*AW-1:0] p_q, p_d;
  logic            v2_q, v2_d;

  always_comb begin
    v1_d = issue;
    a_d  = issue ? a : a_q;
    b_d  = issue ? b : b_q;
    v2_d = v1_q;
    p_d  = v1_q ? ({{AW{1'b0}}, a_q} * {{AW{1'b0}}, b_q}) : p_q;
  end

  // NOTE: every state register uses non-blocking assignment so all flops sample
  // the same pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and product registers are reset too, so a job aborted by
      // reset can never leak a stale product onto out_data.
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      p_q  <= '0;
      v2_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      v1_q <= v1_d;
      p_q  <= p_d;
      v2_q <= v2_d;
    end
  end

  assign p       = p_q;
  assign p_valid = v2_q;

endmodule

// File: rtl/pow4_sched.sv
// Two-requester round-robin front end that computes x^4 by passing each job twice
// through one shared pipelined squaring multiplier (x*x, then x^2*x^2).
module pow4_sched
  import pow4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [NREQ*W-1:0] in_x,
  output logic [NREQ-1:0]   in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*W-1:0]    out_data,
  output logic              out_id
);

  localparam int W2 = 2 * W;
  localparam int W4 = 4 * W;

  state_e          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;

  logic [NREQ-1:0] grant;
  logic            gid;
  logic            issue;
  logic [W2-1:0]   mul_a;
  logic [W2-1:0]   mul_b;
  logic [W4-1:0]   mul_p;
  logic            mul_p_valid;

  assign grant = rr_grant(in_valid, last_grant_q);
  assign gid   = grant[1];

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    in_ready     = '0;
    issue        = 1'b0;
    mul_a        = '0;
    mul_b        = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_id       = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = grant;
        if (|grant) begin
          x_d          = in_x[int'(gid)*W +: W];
          id_d         = gid;
          last_grant_d = gid;
          state_d      = ISS1;
        end
      end
      ISS1: begin
        issue   = 1'b1;
        mul_a   = {{W{1'b0}}, x_q};
        mul_b   = {{W{1'b0}}, x_q};
        state_d = WT1;
      end
      WT1: state_d = ISS2;
      ISS2: begin
        // Product register now holds x^2, which fits exactly in the low 2W bits.
        issue   = 1'b1;
        mul_a   = mul_p[W2-1:0];
        mul_b   = mul_p[W2-1:0];
        state_d = WT2;
      end
      WT2: state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        out_data  = mul_p;
        out_id    = id_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  mul_pipe #(
    .AW(W2)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .issue  (issue),
    .a      (mul_a),
    .b      (mul_b),
    .p      (mul_p),
    .p_valid(mul_p_valid)
  );

  // The second product must be ready exactly when the FSM reaches OUT.
  a_product_ready: assert property (@(posedge clk) disable iff (rst)
    (state_q == WT2) |=> mul_p_valid);

endmodule
